// File: rtl/result_capture.sv
// Capture buffer for filter output samples with fill/overwrite control, readback port,
// and running peak magnitude tracking.
module result_capture #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int WRAP  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wd,
    input  logic signed [WIDTH-1:0] dstore,
    input  logic                    clear,
    input  logic        [AW-1:0]    raddr,
    output logic signed [WIDTH-1:0] rdata,
    output logic        [AW-1:0]    waddr,
    output logic        [AW:0]      count,
    output logic                    full,
    output logic                    ovf,
    output logic        [WIDTH-1:0] peak
);

    localparam logic [0:0] CAPT = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam int unsigned DepthM1 = DEPTH - 1;
    localparam logic [AW:0] DepthCnt = DEPTH[AW:0];
    localparam logic [AW:0] LastCnt  = DepthM1[AW:0];

    logic signed [WIDTH-1:0] mem [DEPTH];

    logic [0:0]              state_q, state_d;
    logic [AW-1:0]           waddr_q, waddr_d;
    logic [AW:0]             count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [WIDTH-1:0]        peak_q, peak_d;
    logic signed [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0]        mag;
    logic                    accept;

    // The most negative sample negates to itself, whose unsigned reading is 2^(WIDTH-1).
    assign mag    = dstore[WIDTH-1] ? WIDTH'(-dstore) : WIDTH'(dstore);
    assign accept = wd && !clear && (state_q == CAPT);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        peak_d  = peak_q;
        if (clear) begin
            state_d = CAPT;
            waddr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            peak_d  = '0;
        end else if (wd) begin
            if (state_q == HOLD) begin
                ovf_d = 1'b1;
            end else begin
                waddr_d = waddr_q + 1'b1;
                if (count_q != DepthCnt) begin
                    count_d = count_q + 1'b1;
                end
                if (mag > peak_q) begin
                    peak_d = mag;
                end
                if (WRAP == 0 && count_q == LastCnt) begin
                    state_d = HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CAPT;
            waddr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            peak_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            peak_q  <= peak_d;
            rdata_q <= mem[raddr];
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[waddr_q] <= dstore;
        end
    end

    assign rdata = rdata_q;
    assign waddr = waddr_q;
    assign count = count_q;
    assign full  = (count_q == DepthCnt);
    assign ovf   = ovf_q;
    assign peak  = peak_q;

endmodule

// File: doc/result_capture.md
RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 20, giving the filter output sample width in bits.
REQ-002 The module SHALL provide parameter DEPTH, default 1024, giving the number of capture buffer entries (power of two).
REQ-003 The module SHALL provide parameter AW, default 10, giving the address width (log2 DEPTH).
REQ-004 The module SHALL provide parameter WRAP, default 0: 0 = stop when full, 1 = circular overwrite.
REQ-005 The module SHALL provide port clk  input  1  single system clock, all logic on rising edge.
REQ-006 The module SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-007 The module SHALL provide port wd  input  1  write strobe, qualifies dstore for one cycle.
REQ-008 The module SHALL provide port dstore  input  WIDTH  signed filter output sample.
REQ-009 The module SHALL provide port clear  input  1  synchronous restart of capture; buffer contents retained.
REQ-010 The module SHALL provide port raddr  input  AW  readback address.
REQ-011 The module SHALL provide port rdata  output  WIDTH  signed registered readback data.
REQ-012 The module SHALL provide port waddr  output  AW  next write address.
REQ-013 The module SHALL provide port count  output  AW+1  number of valid stored samples, saturating at DEPTH.
REQ-014 The module SHALL provide port full  output  1  high when count equals DEPTH.
REQ-015 The module SHALL provide port ovf  output  1  sticky; a strobe was dropped while in HOLD.
REQ-016 The module SHALL provide port peak  output  WIDTH  unsigned maximum |dstore| captured since reset/clear.

Function
REQ-017 The controller SHALL have two states, CAPT (accepting samples) and HOLD (buffer frozen).
REQ-018 In CAPT with wd=1, the block SHALL write dstore to mem[waddr] and increment waddr modulo DEPTH, all at the same edge.
REQ-019 In CAPT with wd=1, count SHALL increment by one and saturate at DEPTH.
REQ-020 In CAPT with wd=1, peak SHALL update to max(peak, |dstore|); |-2^(WIDTH-1)| = 2^(WIDTH-1) exactly, no overflow.
REQ-021 When the DEPTH-th accepted write occurs with WRAP=0, the state SHALL go to HOLD, full SHALL assert and waddr SHALL wrap to 0, all on that same edge.
REQ-022 With WRAP=1, the state SHALL remain CAPT; once full, writes SHALL overwrite the oldest entry, count SHALL hold at DEPTH and full SHALL stay 1.
REQ-023 In HOLD, wd=1 SHALL NOT change memory, waddr, count or peak, and SHALL set ovf=1 until rst or clear.
REQ-024 clear=1 SHALL, at the next edge, set state CAPT and set waddr, count, full, ovf and peak to 0; memory contents and rdata SHALL be unaffected.
REQ-025 When clear and wd are both high in the same cycle, clear SHALL win and the sample SHALL be dropped, uncounted, without setting ovf.
REQ-026 rdata SHALL equal mem[raddr] sampled at the previous edge (1-cycle latency), read every cycle independent of state.
REQ-027 A read and a write to the same address at the same edge SHALL return the old (pre-write) data.
REQ-028 wd=0 SHALL leave all state unchanged except rdata.
REQ-029 Memory SHALL NOT be reset; entries not yet written SHALL be treated as undefined by consumers.

Reset
REQ-030 rst=1 at an edge SHALL set state CAPT, waddr=0, count=0, full=0, ovf=0, peak=0 and rdata=0.
REQ-031 rst SHALL take priority over clear and wd; a strobe in a reset cycle SHALL be discarded.
REQ-032 Reset asserted mid-capture or in HOLD SHALL restart capture at address 0 on the first cycle after deassertion.

Verification
REQ-033 Reset, then wd=1 for 3 cycles with dstore = 5, -7, 3 -> count=3, waddr=3, peak=7; raddr=1 returns -7 one cycle later.
REQ-034 WRAP=0, 1024 consecutive strobes -> full=1 and HOLD after the 1024th edge; a 1025th strobe -> ovf=1, mem[0] unchanged, count=1024.
REQ-035 WRAP=1, 1026 strobes with dstore = index -> full=1, count=1024, waddr=2, mem[0]=1024, mem[1]=1025, mem[2]=2.
REQ-036 dstore=-524288 with wd=1 -> peak=524288; a following 524287 leaves peak at 524288.
REQ-037 clear and wd both high with count=10, ovf=1 -> count=0, waddr=0, ovf=0, peak=0; mem[0..9] still read back prior values.
REQ-038 rst pulsed with wd=1 during capture at count=500 -> all outputs 0 next cycle, rdata=0; the next strobe is written to address 0.
